// File: rtl/acc_cmd_scheduler_if.sv
// RoCC command/response channel bundle between the core and the command scheduler.
interface acc_cmd_scheduler_if;
  logic        io_cmd_valid;
  logic        io_cmd_ready;
  logic [6:0]  io_cmd_bits_inst_funct;
  logic [4:0]  io_cmd_bits_inst_rd;
  logic [63:0] io_cmd_bits_rs1;
  logic [63:0] io_cmd_bits_rs2;
  logic        io_resp_valid;
  logic        io_resp_ready;
  logic [4:0]  io_resp_bits_rd;
  logic [63:0] io_resp_bits_data;

  modport master (
    output io_cmd_valid, io_cmd_bits_inst_funct, io_cmd_bits_inst_rd,
           io_cmd_bits_rs1, io_cmd_bits_rs2, io_resp_ready,
    input  io_cmd_ready, io_resp_valid, io_resp_bits_rd, io_resp_bits_data
  );

  modport slave (
    input  io_cmd_valid, io_cmd_bits_inst_funct, io_cmd_bits_inst_rd,
           io_cmd_bits_rs1, io_cmd_bits_rs2, io_resp_ready,
    output io_cmd_ready, io_resp_valid, io_resp_bits_rd, io_resp_bits_data
  );
endinterface

// File: rtl/acc_cmd_scheduler.sv
// Buffers RoCC commands, executes them one at a time for a per-opcode programmable
// latency, and returns rs1+rs2 as the response; also keeps saturating perf counters.
module acc_cmd_scheduler #(
  parameter int FIFO_DEPTH      = 4,
  parameter int NUM_OPS         = 8,
  parameter int LAT_WIDTH       = 16,
  parameter int DEFAULT_LATENCY = 500,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  acc_cmd_scheduler_if.slave         io,
  input  logic                       cfg_wr_en,
  input  logic [$clog2(NUM_OPS)-1:0] cfg_wr_idx,
  input  logic [LAT_WIDTH-1:0]       cfg_wr_data,
  output logic                       busy,
  output logic [CNT_WIDTH-1:0]       perf_busy_cycles,
  output logic [CNT_WIDTH-1:0]       perf_cmds_done
);

  localparam int IDX_W = $clog2(NUM_OPS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [4:0]       rd;
    logic [63:0]      rs1;
    logic [63:0]      rs2;
  } entry_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  entry_t                fifo_q    [FIFO_DEPTH];
  entry_t                fifo_d    [FIFO_DEPTH];
  logic [LAT_WIDTH-1:0]  lat_tab_q [NUM_OPS];
  logic [LAT_WIDTH-1:0]  lat_tab_d [NUM_OPS];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;

  state_t                state_q, state_d;
  logic [LAT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [4:0]            resp_rd_q, resp_rd_d;
  logic [63:0]           resp_data_q, resp_data_d;
  logic [CNT_WIDTH-1:0]  perf_busy_q, perf_busy_d;
  logic [CNT_WIDTH-1:0]  perf_done_q, perf_done_d;

  logic                  fifo_full, fifo_empty;
  logic                  push, pop;
  entry_t                head;
  logic [LAT_WIDTH-1:0]  head_lat;
  logic                  unused_funct;

  assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = io.io_cmd_valid && !fifo_full;
  // Pop from IDLE, or chained straight out of RESP on the response handshake.
  assign pop        = !fifo_empty &&
                      ((state_q == IDLE) || ((state_q == RESP) && io.io_resp_ready));
  assign head       = fifo_q[rd_ptr_q];
  assign head_lat   = lat_tab_q[head.idx];
  assign unused_funct = ^io.io_cmd_bits_inst_funct;

  assign io.io_cmd_ready      = !fifo_full;
  assign io.io_resp_valid     = resp_valid_q;
  assign io.io_resp_bits_rd   = resp_rd_q;
  assign io.io_resp_bits_data = resp_data_q;
  assign busy                 = (state_q != IDLE) || !fifo_empty;
  assign perf_busy_cycles     = perf_busy_q;
  assign perf_cmds_done       = perf_done_q;

  always_comb begin
    fifo_d    = fifo_q;
    lat_tab_d = lat_tab_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{idx: io.io_cmd_bits_inst_funct[IDX_W-1:0],
                           rd:  io.io_cmd_bits_inst_rd,
                           rs1: io.io_cmd_bits_rs1,
                           rs2: io.io_cmd_bits_rs2};
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    if (cfg_wr_en) begin
      lat_tab_d[cfg_wr_idx] = cfg_wr_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_rd_d    = resp_rd_q;
    resp_data_d  = resp_data_q;
    perf_done_d  = perf_done_q;
    perf_busy_d  = perf_busy_q;

    if ((state_q != IDLE) && (perf_busy_q != '1)) begin
      perf_busy_d = perf_busy_q + CNT_WIDTH'(1);
    end

    case (state_q)
      IDLE: ;
      EXEC: begin
        if (cnt_q == LAT_WIDTH'(1)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - LAT_WIDTH'(1);
        end
      end
      RESP: begin
        if (io.io_resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
          if (perf_done_q != '1) begin
            perf_done_d = perf_done_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Latency comes from the pre-write table, so a same-edge cfg write is not seen.
    if (pop) begin
      state_d      = EXEC;
      resp_valid_d = 1'b0;
      cnt_d        = (head_lat == '0) ? LAT_WIDTH'(1) : head_lat;
      resp_rd_d    = head.rd;
      resp_data_d  = head.rs1 + head.rs2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      for (int unsigned i = 0; i < NUM_OPS; i++) lat_tab_q[i] <= LAT_WIDTH'(DEFAULT_LATENCY);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      perf_busy_q  <= '0;
      perf_done_q  <= '0;
    end else begin
      fifo_q       <= fifo_d;
      lat_tab_q    <= lat_tab_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      perf_busy_q  <= perf_busy_d;
      perf_done_q  <= perf_done_d;
    end
  end

endmodule

// File: tb/tb_acc_cmd_scheduler.sv
// Directed bench for acc_cmd_scheduler: vector table of single commands plus
// hand-written sequences for queueing, back-pressure, reset and table timing.
module tb_acc_cmd_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_wr_en = 1'b0;
  logic [2:0]  cfg_wr_idx = '0;
  logic [15:0] cfg_wr_data = '0;
  logic        busy;
  logic [31:0] perf_busy_cycles;
  logic [31:0] perf_cmds_done;

  always #5 clock = ~clock;

  acc_cmd_scheduler_if bus();

  acc_cmd_scheduler #(
    .FIFO_DEPTH      (4),
    .NUM_OPS         (8),
    .LAT_WIDTH       (16),
    .DEFAULT_LATENCY (500),
    .CNT_WIDTH       (32)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .io               (bus.slave),
    .cfg_wr_en        (cfg_wr_en),
    .cfg_wr_idx       (cfg_wr_idx),
    .cfg_wr_data      (cfg_wr_data),
    .busy             (busy),
    .perf_busy_cycles (perf_busy_cycles),
    .perf_cmds_done   (perf_cmds_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_done = 0;

  typedef struct {
    logic [6:0]  funct;
    logic [4:0]  rd;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] data;
    int          lat;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [15:0] val);
    cfg_wr_en = 1'b1; cfg_wr_idx = idx; cfg_wr_data = val;
    @(negedge clock);
    cfg_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    bus.io_cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_done = 0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_cmd(input logic [6:0] f, input logic [4:0] rd,
                          input logic [63:0] a, input logic [63:0] b);
    int g;
    g = 0;
    bus.io_cmd_valid = 1'b1;
    bus.io_cmd_bits_inst_funct = f;
    bus.io_cmd_bits_inst_rd = rd;
    bus.io_cmd_bits_rs1 = a;
    bus.io_cmd_bits_rs2 = b;
    while (!bus.io_cmd_ready && g < 300) begin
      @(negedge clock);
      g++;
    end
    if (g >= 300) chk("cmd_accept_timeout", 64'd0, 64'd1);
    @(posedge clock);
    @(negedge clock);
    bus.io_cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input int start, input int limit, output int cyc);
    cyc = start;
    while (!bus.io_resp_valid && cyc < limit) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic run_single(input string tag, input vec_t v);
    int cyc;
    send_cmd(v.funct, v.rd, v.rs1, v.rs2);
    wait_valid(0, 700, cyc);
    chk({tag, "_latency"}, 64'(cyc), 64'(v.lat));
    chk({tag, "_rd"}, 64'(bus.io_resp_bits_rd), 64'(v.rd));
    chk({tag, "_data"}, bus.io_resp_bits_data, v.data);
    @(negedge clock);
    exp_done++;
    chk({tag, "_done"}, 64'(perf_cmds_done), 64'(exp_done));
  endtask

  initial begin
    int   cyc;
    vec_t v;

    bus.io_cmd_valid = 1'b0;
    bus.io_cmd_bits_inst_funct = '0;
    bus.io_cmd_bits_inst_rd = '0;
    bus.io_cmd_bits_rs1 = '0;
    bus.io_cmd_bits_rs2 = '0;
    bus.io_resp_ready = 1'b1;

    vecs[0] = '{funct: 7'h01, rd: 5'd1,  rs1: 64'hFFFF_FFFF_FFFF_FFFF, rs2: 64'd2, data: 64'd1, lat: 2};
    vecs[1] = '{funct: 7'h02, rd: 5'd31, rs1: 64'd1000, rs2: 64'd24, data: 64'd1024, lat: 4};
    vecs[2] = '{funct: 7'h0C, rd: 5'd7,  rs1: 64'h1234, rs2: 64'd1, data: 64'h1235, lat: 8};
    vecs[3] = '{funct: 7'h0D, rd: 5'd0,  rs1: 64'h8000_0000_0000_0000,
                rs2: 64'h8000_0000_0000_0000, data: 64'd0, lat: 2};
    vecs[4] = '{funct: 7'h79, rd: 5'd18, rs1: 64'd5, rs2: 64'd6, data: 64'd11, lat: 2};

    @(negedge clock);
    do_reset();

    chk("rst_cmd_ready", 64'(bus.io_cmd_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.io_resp_valid), 64'd0);
    chk("rst_resp_rd", 64'(bus.io_resp_bits_rd), 64'd0);
    chk("rst_resp_data", bus.io_resp_bits_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_perf_busy", 64'(perf_busy_cycles), 64'd0);
    chk("rst_perf_done", 64'(perf_cmds_done), 64'd0);

    // Default latency: valid 501 cycles after accept, 501 busy cycles incl. RESP.
    v = '{funct: 7'h00, rd: 5'd5, rs1: 64'd100, rs2: 64'd11, data: 64'd111, lat: 501};
    run_single("default", v);
    chk("default_perf_busy", 64'(perf_busy_cycles), 64'd501);
    chk("default_idle_busy", 64'(busy), 64'd0);

    cfg_write(3'd1, 16'd0);
    cfg_write(3'd2, 16'd3);
    cfg_write(3'd4, 16'd7);
    cfg_write(3'd5, 16'd1);
    for (int i = 0; i < 5; i++) begin
      run_single($sformatf("vec%0d", i), vecs[i]);
    end

    // Five back-to-back funct=2 commands (latency 3) with a concurrent collector.
    fork
      begin
        int g;
        for (int i = 0; i < 5; i++) begin
          g = 0;
          bus.io_cmd_valid = 1'b1;
          bus.io_cmd_bits_inst_funct = 7'h02;
          bus.io_cmd_bits_inst_rd = 5'(10 + i);
          bus.io_cmd_bits_rs1 = 64'(i * 100);
          bus.io_cmd_bits_rs2 = 64'(i);
          while (!bus.io_cmd_ready && g < 300) begin
            @(negedge clock);
            g++;
          end
          if (g >= 300) chk("b2b_accept_timeout", 64'd0, 64'd1);
          @(posedge clock);
          @(negedge clock);
        end
        bus.io_cmd_valid = 1'b0;
        chk("b2b_ready_low_when_full", 64'(bus.io_cmd_ready), 64'd0);
      end
      begin
        int c;
        for (int j = 0; j < 5; j++) begin
          wait_valid(0, 200, c);
          chk($sformatf("b2b_rd%0d", j), 64'(bus.io_resp_bits_rd), 64'(10 + j));
          chk($sformatf("b2b_data%0d", j), bus.io_resp_bits_data, 64'(101 * j));
          if (j > 0) chk($sformatf("b2b_gap%0d", j), 64'(c), 64'd3);
          exp_done++;
          @(negedge clock);
        end
      end
    join
    chk("b2b_done", 64'(perf_cmds_done), 64'(exp_done));
    chk("b2b_idle", 64'(busy), 64'd0);

    // Reset mid-EXEC with two commands still queued.
    send_cmd(7'h06, 5'd3, 64'd1, 64'd1);
    send_cmd(7'h06, 5'd4, 64'd1, 64'd1);
    send_cmd(7'h06, 5'd6, 64'd1, 64'd1);
    repeat (10) @(negedge clock);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_resp_valid", 64'(bus.io_resp_valid), 64'd0);
    chk("midrst_cmd_ready", 64'(bus.io_cmd_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_perf_busy", 64'(perf_busy_cycles), 64'd0);
    chk("midrst_perf_done", 64'(perf_cmds_done), 64'd0);
    chk("midrst_resp_data", bus.io_resp_bits_data, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_done = 0;
    v = '{funct: 7'h02, rd: 5'd9, rs1: 64'd7, rs2: 64'd8, data: 64'd15, lat: 501};
    run_single("post_rst_table", v);

    // Back-pressure in RESP from a fresh reset so perf_busy_cycles is absolute.
    do_reset();
    cfg_write(3'd2, 16'd3);
    bus.io_resp_ready = 1'b0;
    send_cmd(7'h02, 5'd9, 64'd40, 64'd2);
    wait_valid(0, 50, cyc);
    chk("hold_latency", 64'(cyc), 64'd4);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k % 5 == 0) begin
        chk($sformatf("hold_valid_%0d", k), 64'(bus.io_resp_valid), 64'd1);
        chk($sformatf("hold_rd_%0d", k), 64'(bus.io_resp_bits_rd), 64'd9);
        chk($sformatf("hold_data_%0d", k), bus.io_resp_bits_data, 64'd42);
        chk($sformatf("hold_perf_busy_%0d", k), 64'(perf_busy_cycles), 64'(3 + k));
        chk($sformatf("hold_perf_done_%0d", k), 64'(perf_cmds_done), 64'd0);
      end
    end
    bus.io_resp_ready = 1'b1;
    @(negedge clock);
    chk("hold_release_valid", 64'(bus.io_resp_valid), 64'd0);
    chk("hold_release_done", 64'(perf_cmds_done), 64'd1);
    chk("hold_release_perf_busy", 64'(perf_busy_cycles), 64'd24);
    exp_done = 1;

    // Table write on the same edge the funct=3 command pops: old value 4 applies.
    cfg_write(3'd3, 16'd4);
    send_cmd(7'h03, 5'd12, 64'd3, 64'd4);
    cfg_wr_en = 1'b1; cfg_wr_idx = 3'd3; cfg_wr_data = 16'd10;
    @(negedge clock);
    cfg_wr_en = 1'b0;
    wait_valid(1, 50, cyc);
    chk("same_edge_latency", 64'(cyc), 64'd5);
    chk("same_edge_data", bus.io_resp_bits_data, 64'd7);
    @(negedge clock);
    exp_done++;
    v = '{funct: 7'h03, rd: 5'd13, rs1: 64'd20, rs2: 64'd22, data: 64'd42, lat: 11};
    run_single("after_write", v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
